// File: rtl/data_mem_unit_pkg.sv
// Purpose: shared constants, types and helpers for data_mem_unit.
// Contents: address map, legal byte-lane masks, RAM geometry, the region
// decoder and the mask/alignment legality check.
package data_mem_unit_pkg;

    localparam int RAM_WORDS = 252;
    localparam int RAM_AW    = 8;

    localparam logic [9:0] RAM_TOP     = 10'h3EF;
    localparam logic [9:0] GPIO_ADDR   = 10'h3F0;
    localparam logic [9:0] CYCLE_ADDR  = 10'h3F4;
    localparam logic [9:0] STATUS_ADDR = 10'h3F8;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_GPIO,
        REG_CYCLE,
        REG_STATUS,
        REG_RSVD
    } region_e;

    // Decode on the word index only; the byte offset never changes the region.
    function automatic region_e decode(input logic [9:0] addr);
        if (addr <= RAM_TOP)                   return REG_RAM;
        if (addr[9:2] == GPIO_ADDR[9:2])       return REG_GPIO;
        if (addr[9:2] == CYCLE_ADDR[9:2])      return REG_CYCLE;
        if (addr[9:2] == STATUS_ADDR[9:2])     return REG_STATUS;
        return REG_RSVD;
    endfunction

    // A mask is legal only if it is one of the aligned byte/half/word shapes
    // and its lowest enabled lane matches the address byte offset.
    function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] off);
        case (mask)
            MASK_B0, MASK_H0, MASK_W: return off == 2'd0;
            MASK_B1:                  return off == 2'd1;
            MASK_B2, MASK_H1:         return off == 2'd2;
            MASK_B3:                  return off == 2'd3;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_dmem_bram.sv
// Purpose: single-port 32-bit data RAM with per-byte write enables and a
// synchronous read-first output register.
// Ports: clk; addr_i word index; we_i byte-lane write enables;
//        wdata_i lane-aligned store data; rdata_o word read at the previous edge.
module dmem_bram
    import data_mem_unit_pkg::*;
(
    input  logic              clk,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [3:0]        we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [RAM_WORDS];
    logic [31:0] rdata_q;

    // NOTE: memory arrays carry no reset so they map onto block RAM; only
    // control state around them is reset.
    // NOTE: non-blocking assignments make the read sample the pre-write word,
    // giving read-first behaviour on a same-word store.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[addr_i];
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Purpose: CPU data-memory unit: 252-word RAM plus GPIO, free-running CYCLE
// counter and STATUS (sticky misalignment flag, write-1-to-clear).
// Ports: clk, rst_n (async, active-low); data_address byte address;
//        wdata store data; width byte-lane mask; write_mem store request;
//        data_in read word (latency 1); gpio_out GPIO register;
//        misalign_err one-cycle pulse after an illegal store.
module data_mem_unit
    import data_mem_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  data_address,
    input  logic [31:0] wdata,
    input  logic [3:0]  width,
    input  logic        write_mem,
    output logic [31:0] data_in,
    output logic [7:0]  gpio_out,
    output logic        misalign_err
);

    region_e     region;
    logic        legal;
    logic        store_ok;
    logic        store_bad;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;

    logic [7:0]  gpio_q,   gpio_d;
    logic [31:0] cycle_q,  cycle_d;
    logic        status_q, status_d;
    logic        err_q,    err_d;
    logic [31:0] periph_q, periph_d;
    logic        sel_ram_q, sel_ram_d;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        region    = decode(data_address);
        legal     = mask_legal(width, data_address[1:0]);
        store_ok  = write_mem & legal;
        store_bad = write_mem & ~legal;
        // RAM is not reset, so its write port is blocked while reset is held.
        ram_we    = (store_ok && region == REG_RAM && rst_n) ? width : 4'b0000;

        gpio_d = gpio_q;
        if (store_ok && region == REG_GPIO && width[0]) begin
            gpio_d = wdata[7:0];
        end

        // Clear first, then set, so an error in the same cycle wins.
        status_d = status_q;
        if (store_ok && region == REG_STATUS && width[0] && wdata[0]) begin
            status_d = 1'b0;
        end
        if (store_bad) begin
            status_d = 1'b1;
        end

        err_d   = store_bad;
        cycle_d = cycle_q + 32'd1;

        // Peripheral read value uses current (pre-write) register contents.
        periph_d = 32'd0;
        case (region)
            REG_GPIO:   periph_d = {24'd0, gpio_q};
            REG_CYCLE:  periph_d = cycle_q;
            REG_STATUS: periph_d = {31'd0, status_q};
            default:    periph_d = 32'd0;
        endcase
        sel_ram_d = (region == REG_RAM);
    end

    dmem_bram u_dmem_bram (
        .clk     (clk),
        .addr_i  (data_address[9:2]),
        .we_i    (ram_we),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q    <= '0;
            cycle_q   <= '0;
            status_q  <= 1'b0;
            err_q     <= 1'b0;
            periph_q  <= '0;
            sel_ram_q <= 1'b0;
        end else begin
            gpio_q    <= gpio_d;
            cycle_q   <= cycle_d;
            status_q  <= status_d;
            err_q     <= err_d;
            periph_q  <= periph_d;
            sel_ram_q <= sel_ram_d;
        end
    end

    // Both mux inputs are registered; the RAM leg is forced off by reset so
    // data_in reads zero as soon as reset asserts.
    assign data_in      = sel_ram_q ? ram_rdata : periph_q;
    assign gpio_out     = gpio_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  data_address;
    logic [31:0] wdata;
    logic [3:0]  width;
    logic        write_mem;
    logic [31:0] data_in;
    logic [7:0]  gpio_out;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    data_mem_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_address (data_address),
        .wdata        (wdata),
        .width        (width),
        .write_mem    (write_mem),
        .data_in      (data_in),
        .gpio_out     (gpio_out),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, sample 1ns after the edge.
    task automatic step(input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic we);
        data_address = a;
        wdata        = d;
        width        = m;
        write_mem    = we;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [9:0] a);
        step(a, 32'd0, 4'b0000, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        data_address = 10'h3F4;
        wdata        = 32'd0;
        width        = 4'b0000;
        write_mem    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_data_in", data_in, 32'd0);
        check("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("rst_err", {31'd0, misalign_err}, 32'd0);
        rst_n = 1'b1;

        // CYCLE counts 0,1,2 from the first edge after reset.
        rd(10'h3F4); check("cycle0", data_in, 32'd0);
        rd(10'h3F4); check("cycle1", data_in, 32'd1);
        rd(10'h3F4); check("cycle2", data_in, 32'd2);

        // Wrap through 0xFFFFFFFF.
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        rd(10'h3F4); check("cycle_fffe", data_in, 32'hFFFF_FFFE);
        rd(10'h3F4); check("cycle_ffff", data_in, 32'hFFFF_FFFF);
        rd(10'h3F4); check("cycle_wrap", data_in, 32'd0);

        rd(10'h3F8); check("status_reset", data_in, 32'd0);
        rd(10'h3FC); check("rsvd_read", data_in, 32'd0);

        // RAM word store and partial stores.
        step(10'h010, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        check("word_store_err", {31'd0, misalign_err}, 32'd0);
        rd(10'h010); check("word_read", data_in, 32'hDEAD_BEEF);
        step(10'h011, 32'h0000_AA00, 4'b0010, 1'b1);
        check("read_first", data_in, 32'hDEAD_BEEF);
        check("byte1_err", {31'd0, misalign_err}, 32'd0);
        step(10'h011, 32'h0000_BB00, 4'b0011, 1'b1);
        check("illegal_err", {31'd0, misalign_err}, 32'd1);
        check("illegal_rd", data_in, 32'hDEAD_AAEF);
        rd(10'h3F8);
        check("err_pulse_end", {31'd0, misalign_err}, 32'd0);
        check("status_set", data_in, 32'd1);
        rd(10'h010); check("word_unchanged", data_in, 32'hDEAD_AAEF);
        step(10'h012, 32'h5566_0000, 4'b1100, 1'b1);
        step(10'h013, 32'h7700_0000, 4'b1000, 1'b1);
        rd(10'h010); check("half_byte3", data_in, 32'h7766_AAEF);
        step(10'h3EC, 32'hCAFE_F00D, 4'b1111, 1'b1);
        rd(10'h3EC); check("last_ram_word", data_in, 32'hCAFE_F00D);
        step(10'h010, 32'h1111_1111, 4'b0000, 1'b1);
        check("mask0_err", {31'd0, misalign_err}, 32'd1);
        step(10'h011, 32'h1111_1111, 4'b0011, 1'b0);
        check("no_store_no_err", {31'd0, misalign_err}, 32'd0);
        rd(10'h010); check("idle_no_write", data_in, 32'h7766_AAEF);

        // GPIO.
        step(10'h3F0, 32'h0000_0011, 4'b0001, 1'b1);
        check("gpio_rd_prewrite", data_in, 32'd0);
        check("gpio_out_11", {24'd0, gpio_out}, 32'h11);
        rd(10'h3F0); check("gpio_read_11", data_in, 32'h11);
        step(10'h3F0, 32'hFFFF_FF22, 4'b1111, 1'b1);
        check("gpio_lane0", {24'd0, gpio_out}, 32'h22);
        step(10'h3F1, 32'h0000_9900, 4'b0010, 1'b1);
        check("gpio_lane1_ign", {24'd0, gpio_out}, 32'h22);
        rd(10'h3F0); check("gpio_read_22", data_in, 32'h22);

        // CYCLE and reserved stores are legal no-ops.
        step(10'h3F4, 32'h1234_5678, 4'b1111, 1'b1);
        check("cycle_store_err", {31'd0, misalign_err}, 32'd0);
        step(10'h3FC, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        rd(10'h3FC); check("rsvd_ignored", data_in, 32'd0);

        // STATUS write-1-to-clear and set-wins.
        step(10'h3F8, 32'd1, 4'b0001, 1'b1);
        rd(10'h3F8); check("status_w1c", data_in, 32'd0);
        step(10'h3F9, 32'd1, 4'b0011, 1'b1);
        check("status_set_err", {31'd0, misalign_err}, 32'd1);
        rd(10'h3F8); check("status_set_wins", data_in, 32'd1);
        step(10'h3F8, 32'd0, 4'b0001, 1'b1);
        rd(10'h3F8); check("status_w0_keeps", data_in, 32'd1);

        // Reset asserted in the middle of a store.
        rd(10'h010);
        step(10'h011, 32'd0, 4'b0001, 1'b1);
        check("pre_rst_err", {31'd0, misalign_err}, 32'd1);
        check("pre_rst_data", data_in, 32'h7766_AAEF);
        data_address = 10'h010;
        wdata        = 32'd0;
        width        = 4'b1111;
        write_mem    = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_in, 32'd0);
        check("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("mid_rst_err", {31'd0, misalign_err}, 32'd0);
        @(posedge clk);
        #2;
        write_mem = 1'b0;
        rst_n     = 1'b1;
        rd(10'h010); check("ram_after_rst", data_in, 32'h7766_AAEF);
        rd(10'h3F8); check("status_after_rst", data_in, 32'd0);
        rd(10'h3F4); check("cycle_after_rst", data_in, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
